cache_refill_unit: RTL and testbench

- Upstream neighbour of the cache return buffer: an AXI4 read-burst master that fetches one full cache line on a miss.
- Collects the beats into a line-wide register, then pulses a write enable so the return buffer captures the line in one cycle.
- Sits between the cache miss FSM (request side) and the AXI read channels (memory side). Outputs `line_data`/`line_we` feed the return buffer's `in`/`we`.

---
 rtl/cache_refill_unit.sv | 149 ++++++++++++++
 tb/tb_cache_refill_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_unit.sv
// cache_refill_unit
// AXI4 read-burst master that fetches one full cache line on a miss.
// The beats are collected into a line-wide register. A single-cycle
// line_we pulse then lets the downstream return buffer capture the line.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   req_valid/ready     refill request handshake from the cache miss FSM
//   req_addr            miss address (line offset bits are ignored)
//   arid..arready       AXI4 read-address channel (single INCR burst per line)
//   rdata..rready       AXI4 read-data channel
//   line_data           assembled line; word i sits at bits [32i+31:32i]
//   line_we             one-cycle pulse: line_data is complete
//   refill_err          valid with line_we; set on a bad rresp or a misplaced rlast
module cache_refill_unit #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int AXI_ID     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic [3:0]               arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic                     line_we,
  output logic                     refill_err
);

  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int OFF_W  = CNT_W + 2;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt;
  logic                err_q;
  logic [LINE_W-1:0]   line_q;
  logic                beat;
  logic                unused_offset;

  // The offset bits of the miss address never reach the bus.
  assign unused_offset = ^req_addr[OFF_W-1:0];

  // Burst shape is fixed: one INCR burst of LINE_WORDS 4-byte beats.
  assign arid      = 4'(AXI_ID);
  assign arlen     = 8'(LINE_WORDS - 1);
  assign arsize    = 3'b010;
  assign arburst   = 2'b01;
  assign araddr    = addr_q;
  assign line_data = line_q;

  // An R beat is accepted whenever we sit in R and the slave offers data;
  // rready itself only depends on state, so there is no rvalid->rready path.
  assign beat = (state == R) && rvalid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs. All outputs come from state, so a
  // reset forcing state back to IDLE silences the bus at once. req_ready is
  // additionally gated by rst so nothing is accepted while held in reset.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    line_we    = 1'b0;
    refill_err = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst;
        if (req_valid) begin
          state_next = AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_next = R;
        end
      end
      R: begin
        rready = 1'b1;
        // Either the expected last beat or an early rlast ends the burst.
        if (rvalid && ((cnt == LAST_BEAT) || rlast)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        line_we    = 1'b1;
        refill_err = err_q;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: line-aligned address latch, beat counter, line assembly and
  // the sticky error flag. The line register is only written on accepted
  // beats, so it holds steady through and after line_we. rlast must line up
  // exactly with the final beat; a mismatch in either direction is an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      line_q <= '0;
    end else begin
      if ((state == IDLE) && req_valid) begin
        addr_q <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        err_q  <= 1'b0;
      end
      if ((state == AR) && arready) begin
        cnt <= '0;
      end
      if (beat) begin
        line_q[cnt*32 +: 32] <= rdata;
        cnt                  <= cnt + CNT_W'(1);
        err_q                <= err_q | (rresp != 2'b00) | (rlast != (cnt == LAST_BEAT));
      end
    end
  end

endmodule

// File: tb/tb_cache_refill_unit.sv
// tb_cache_refill_unit
// Self-checking bench for cache_refill_unit (LINE_WORDS=4, ADDR_W=32).
// A table of refill records drives the AXI slave side. Expected lines are
// queued when a request is accepted and popped when line_we is seen.
module tb_cache_refill_unit;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [127:0] line_data;
  logic         line_we;
  logic         refill_err;

  cache_refill_unit #(
    .LINE_WORDS(4),
    .ADDR_W    (32),
    .AXI_ID    (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .line_data (line_data),
    .line_we   (line_we),
    .refill_err(refill_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] words;
    logic [7:0]   resp;
    int           n_beats;
    int           rlast_at;
    int           ar_stall;
    int           r_gap;
    logic [31:0]  exp_araddr;
    logic [127:0] exp_line;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  typedef struct {
    logic [127:0] line;
    logic         err;
    int           lat;
    int           idx;
  } exp_t;

  vec_t vecs[8];
  exp_t sbq[$];
  exp_t mon_e;

  int total_checks = 0;
  int passed_checks = 0;
  int cycle_cnt = 0;
  int accept_cyc = 0;
  int we_count = 0;
  int exp_we = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    total_checks++;
    if (act === exp_v) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp_v);
    end
  endtask

  task automatic reportTimeout(input string name);
    total_checks++;
    $display("[TB] FAIL %s: actual=no handshake required=handshake within 50 cycles", name);
  endtask

  // Line writes are checked against the scoreboard the moment they appear.
  always @(negedge clk) begin
    if (line_we) begin
      we_count++;
      if (sbq.size() == 0) begin
        total_checks++;
        $display("[TB] FAIL unexpected_line_we: actual=pulse required=none");
      end else begin
        mon_e = sbq.pop_front();
        checkOutput($sformatf("line_data[%0d]", mon_e.idx), line_data, mon_e.line);
        checkOutput($sformatf("refill_err[%0d]", mon_e.idx), 128'(refill_err), 128'(mon_e.err));
        if (mon_e.lat > 0) begin
          checkOutput($sformatf("latency[%0d]", mon_e.idx),
                      128'(cycle_cnt - accept_cyc + 1), 128'(mon_e.lat));
        end
      end
    end
  end

  // Runs one refill from the table, acting as the AXI slave.
  // Entered and left at a negedge with the DUT idle.
  task automatic applyStimulus(input int idx);
    vec_t v;
    int   n;
    v = vecs[idx];
    req_addr  = v.addr;
    req_valid = 1'b1;
    arready   = (v.ar_stall == 0);
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = 2'b00;
    checkOutput($sformatf("req_ready_idle[%0d]", idx), 128'(req_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    accept_cyc = cycle_cnt;
    req_valid  = 1'b0;
    sbq.push_back('{v.exp_line, v.exp_err, v.exp_lat, idx});

    // Stalled AR: address must stay put, garbage beats must be ignored.
    if (v.ar_stall > 0) begin
      rvalid = 1'b1;
      rdata  = 32'hBAD0_0000;
      rresp  = 2'b11;
      rlast  = 1'b1;
      for (int i = 0; i < v.ar_stall; i++) begin
        @(negedge clk);
        checkOutput($sformatf("ar_stall_hold[%0d]", idx),
                    128'({arvalid, araddr, req_ready, rready}),
                    128'({1'b1, v.exp_araddr, 1'b0, 1'b0}));
        @(posedge clk);
        #1;
      end
      arready = 1'b1;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
    end

    n = 0;
    @(negedge clk);
    while (!arvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arvalid) begin
      reportTimeout($sformatf("ar_handshake[%0d]", idx));
      arready = 1'b0;
      return;
    end
    checkOutput($sformatf("araddr[%0d]", idx), 128'(araddr), 128'(v.exp_araddr));
    checkOutput($sformatf("ar_fields[%0d]", idx),
                128'({arid, arlen, arsize, arburst}),
                128'({4'd0, 8'd3, 3'd2, 2'd1}));
    @(posedge clk);
    #1;
    arready = 1'b0;

    for (int b = 0; b < v.n_beats; b++) begin
      if (b > 0) begin
        for (int g = 0; g < v.r_gap; g++) begin
          rvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      rvalid = 1'b1;
      rdata  = v.words[32*b +: 32];
      rresp  = v.resp[2*b +: 2];
      rlast  = (b == v.rlast_at);
      n = 0;
      @(negedge clk);
      while (!rready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!rready) begin
        reportTimeout($sformatf("r_beat%0d[%0d]", b, idx));
        rvalid = 1'b0;
        return;
      end
      if (v.r_gap > 0) begin
        checkOutput($sformatf("req_ready_busy[%0d]", idx), 128'(req_ready), 128'(1'b0));
      end
      @(posedge clk);
      #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    exp_we++;

    // DONE lasts one cycle; afterwards exactly one pulse must have been seen.
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput($sformatf("line_we_count[%0d]", idx), 128'(we_count), 128'(exp_we));
    checkOutput($sformatf("line_we_low[%0d]", idx), 128'(line_we), 128'(1'b0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //          addr          words (w3..w0)                                   resp   nb rl  st gp araddr        expected line                                   err lat
    vecs[0] = '{32'h1C00_0014, 128'h00000044_00000033_00000022_00000011, 8'h00, 4, 3, 0, 0, 32'h1C00_0010,
                128'h00000044_00000033_00000022_00000011, 1'b0, 6};
    vecs[1] = '{32'h2000_003C, 128'h000000D4_000000C3_000000B2_000000A1, 8'h00, 4, 3, 5, 2, 32'h2000_0030,
                128'h000000D4_000000C3_000000B2_000000A1, 1'b0, 0};
    vecs[2] = '{32'h0000_1008, 128'h00004444_00003333_00002222_00001111, 8'h08, 4, 3, 0, 0, 32'h0000_1000,
                128'h00004444_00003333_00002222_00001111, 1'b1, 6};
    vecs[3] = '{32'h0000_2000, 128'h00000008_00000007_00000006_00000005, 8'h00, 4, 3, 0, 0, 32'h0000_2000,
                128'h00000008_00000007_00000006_00000005, 1'b0, 6};
    vecs[4] = '{32'h0000_3004, 128'h00000000_00000000_000000BB_000000AA, 8'h00, 2, 1, 0, 0, 32'h0000_3000,
                128'h00000008_00000007_000000BB_000000AA, 1'b1, 4};
    vecs[5] = '{32'hFFFF_FFFF, 128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF, 8'h00, 4, 3, 0, 0, 32'hFFFF_FFF0,
                128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF, 1'b0, 6};
    vecs[6] = '{32'h4000_0000, 128'h00000004_00000003_00000002_00000001, 8'h00, 4, -1, 0, 0, 32'h4000_0000,
                128'h00000004_00000003_00000002_00000001, 1'b1, 6};
    vecs[7] = '{32'h6000_0008, 128'h00000040_00000030_00000020_00000010, 8'h00, 4, 3, 0, 0, 32'h6000_0000,
                128'h00000040_00000030_00000020_00000010, 1'b0, 6};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    arready   = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;

    #12;
    checkOutput("reset_outputs",
                128'({req_ready, arvalid, rready, line_we, refill_err}), 128'(5'b0));
    checkOutput("reset_line", line_data, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(i);
    end

    // Asynchronous reset after the second beat of a burst.
    req_addr  = 32'h5000_0004;
    req_valid = 1'b1;
    arready   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h5555_0001;
    @(posedge clk);
    #1;
    rdata = 32'h5555_0002;
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    #2;
    checkOutput("mid_burst_line", 128'(line_data[63:0]), 128'(64'h55550002_55550001));
    checkOutput("mid_burst_rready", 128'(rready), 128'(1'b1));
    rst = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                128'({arvalid, rready, line_we, req_ready}), 128'(4'b0));
    checkOutput("async_reset_line", line_data, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_req_ready", 128'(req_ready), 128'(1'b1));
    checkOutput("post_reset_no_we", 128'(we_count), 128'(exp_we));

    applyStimulus(7);

    checkOutput("scoreboard_empty", 128'(sbq.size()), 128'h0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
